sample_streamer: RTL and testbench
==================================

SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 SHALL have parameter NUMBER_WIDTH, default 16, sample word width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, buffer depth = 2**DEPTH_LOG2 samples.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_data  input  NUMBER_WIDTH  sample pushed into buffer.
REQ-006 SHALL have port wr_en  input  1  push strobe for wr_data.
REQ-007 SHALL have port start  input  1  one-cycle request to begin streaming.
REQ-008 SHALL have port rate_div  input  8  emit period minus one, in clk cycles.
REQ-009 SHALL have port full  output  1  buffer holds 2**DEPTH_LOG2 samples.
REQ-010 SHALL have port overflow  output  1  sticky; a push was dropped.
REQ-011 SHALL have port output_number  output  NUMBER_WIDTH  sample to the filter input_number.
REQ-012 SHALL have port output_valid  output  1  one-cycle strobe to the filter input_valid.
REQ-013 SHALL have port busy  output  1  high while not in IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a stream ends.

Function
REQ-015 SHALL be a FIFO producer for the filter's number/valid input; no backpressure exists, the consumer accepts every valid cycle.
REQ-016 SHALL accept a push when wr_en=1 and full=0 (full evaluated before this edge's pop); otherwise the word is dropped and overflow is set.
REQ-017 SHALL update occupancy as count_next = count + push - pop; simultaneous push and pop leave count unchanged.
REQ-018 SHALL implement states IDLE, WAIT, EMIT.
REQ-019 IDLE: on start=1 with count>0, latch rate_div into period register, load divider with 0, go to EMIT; start with count=0 is ignored, no done.
REQ-020 EMIT: pop head, drive output_number=head and output_valid=1 for exactly this cycle; if count_next=0 go IDLE and pulse done the same cycle, else load divider with latched period and go WAIT (or stay EMIT if period=0).
REQ-021 WAIT: decrement divider; when divider reaches 1 go EMIT; successive valids are exactly period+1 cycles apart.
REQ-022 SHALL hold output_number at last emitted value between strobes; output_valid=0 outside EMIT.
REQ-023 SHALL ignore start while busy=1; rate_div changes while busy take effect only at next start.
REQ-024 Pushes during a stream SHALL extend it; a push coincident with the final pop (count=1) SHALL keep the stream running.
REQ-025 overflow SHALL stay 1 until reset.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, empty buffer (count=0, pointers 0), output_number=0, output_valid=0, busy=0, done=0, full=0, overflow=0; buffer contents need not clear.
REQ-027 Reset mid-stream SHALL abort without done pulse; wr_en and start are ignored on reset cycles.

Configuration
REQ-028 Macro SAMPLE_STREAMER_LAST_EN SHALL, when defined, add output port output_last (1 bit) high with output_valid on the final sample of a stream (the EMIT cycle that pulses done), reset 0.
REQ-029 Without SAMPLE_STREAMER_LAST_EN the output_last port SHALL not exist and behaviour is otherwise identical.

Verification
REQ-030 Push 10,20,30,40, rate_div=0, start -> output_valid 4 consecutive cycles carrying 10,20,30,40; done with 40; busy falls next cycle.
REQ-031 Push 5,6, rate_div=3, start -> valids 4 cycles apart (5 then 6); done with 6.
REQ-032 Push 17 words with DEPTH_LOG2=4 -> full=1 after 16th, 17th dropped, overflow=1 until reset; stream emits exactly 16 words.
REQ-033 Push 1 word, start, rate_div=2; push 99 in the final EMIT cycle -> stream continues, 99 emitted 3 cycles later, single done.
REQ-034 start with empty buffer -> busy stays 0, no valid, no done; rst_n=0 during WAIT -> next cycle all outputs 0, no done, buffer empty.
REQ-035 With SAMPLE_STREAMER_LAST_EN, 3-word stream -> output_last=1 only on third valid.

Source files
------------

// File: rtl/sample_streamer.sv
// -----------------------------------------------------------------------------
// sample_streamer
//
// Buffers samples in a small FIFO and, on request, streams them out as
// number/valid strobes to a downstream filter at a programmable rate.
// The consumer has no backpressure: every output_valid cycle is accepted.
//
// Handshake: output_valid is a one-cycle strobe. output_number carries the
// sample during that cycle and holds the last emitted value otherwise.
// There is no ready signal, so every strobe counts as a transfer.
//
// Parameters
//   NUMBER_WIDTH : sample word width
//   DEPTH_LOG2   : buffer holds 2**DEPTH_LOG2 samples
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : synchronous active-low reset
//   wr_data       : sample to push
//   wr_en         : push strobe
//   start         : one-cycle request to begin streaming (ignored while busy)
//   rate_div      : emit period minus one, latched at start
//   full          : buffer holds 2**DEPTH_LOG2 samples
//   overflow      : sticky, a push was dropped because the buffer was full
//   output_number : sample to the filter
//   output_valid  : one-cycle strobe to the filter
//   busy          : high while not idle
//   done          : one-cycle pulse on the final emitted sample
//   fsm_state     : current FSM state (debug visibility)
//   output_last   : only with SAMPLE_STREAMER_LAST_EN defined; high with
//                   output_valid on the final sample of a stream
//
// Configuration macro: SAMPLE_STREAMER_LAST_EN
// -----------------------------------------------------------------------------
module sample_streamer #(
  parameter int NUMBER_WIDTH = 16,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUMBER_WIDTH-1:0] wr_data,
  input  logic                    wr_en,
  input  logic                    start,
  input  logic [7:0]              rate_div,
  output logic                    full,
  output logic                    overflow,
  output logic [NUMBER_WIDTH-1:0] output_number,
  output logic                    output_valid,
  output logic                    busy,
  output logic                    done,
`ifdef SAMPLE_STREAMER_LAST_EN
  output logic                    output_last,
`endif
  output logic [1:0]              fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUMBER_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;

  logic [7:0]              period, period_next;
  logic [7:0]              div, div_next;
  logic [NUMBER_WIDTH-1:0] last_number;
  logic                    overflow_q;

  logic                    push;
  logic                    pop;
  logic                    stream_end;

  // full is taken from the occupancy before this edge's pop, so a push into
  // a full buffer is dropped even when a pop happens in the same cycle.
  assign full = (count == CW'(DEPTH));
  assign push = wr_en && !full;
  assign pop  = (state == ST_EMIT);

  always_comb begin
    count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    period_next = period;
    div_next    = div;
    stream_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (count != '0)) begin
          period_next = rate_div;
          div_next    = 8'd0;
          state_next  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // A push arriving with the final pop keeps count_next non-zero,
        // so the stream continues instead of ending.
        if (count_next == '0) begin
          stream_end = 1'b1;
          state_next = ST_IDLE;
        end else if (period == 8'd0) begin
          state_next = ST_EMIT;
        end else begin
          div_next   = period;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        div_next = div - 8'd1;
        // div counts period..1; leaving at 1 gives period+1 cycles between
        // successive strobes.
        if (div <= 8'd1) begin
          state_next = ST_EMIT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointers, occupancy and held output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      period      <= 8'd0;
      div         <= 8'd0;
      last_number <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state  <= state_next;
      period <= period_next;
      div    <= div_next;
      count  <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        last_number <= mem[rd_ptr];
      end
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign output_valid  = (state == ST_EMIT);
  assign output_number = output_valid ? mem[rd_ptr] : last_number;
  assign busy          = (state != ST_IDLE);
  // A cycle with rst_n low aborts the stream, so it never reports an end.
  assign done          = stream_end && rst_n;
  assign overflow      = overflow_q;
  assign fsm_state     = state;

`ifdef SAMPLE_STREAMER_LAST_EN
  assign output_last = done;
`endif

endmodule

// File: tb/tb_sample_streamer.sv
// -----------------------------------------------------------------------------
// tb_sample_streamer
//
// Directed bench for sample_streamer. A queue-based model of the buffer and
// stream timing predicts every output each cycle. Directed tests also check
// emitted values, strobe spacing and done pulses against hand-computed
// literals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sample_streamer;

  localparam int W     = 16;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n    = 1'b0;
  logic [W-1:0]  wr_data  = '0;
  logic          wr_en    = 1'b0;
  logic          start    = 1'b0;
  logic [7:0]    rate_div = 8'd0;
  logic          full, overflow, output_valid, busy, done;
  logic [W-1:0]  output_number;
  logic [1:0]    fsm_state;
`ifdef SAMPLE_STREAMER_LAST_EN
  logic          output_last;
`endif

  sample_streamer #(.NUMBER_WIDTH(W), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .start(start), .rate_div(rate_div), .full(full), .overflow(overflow),
    .output_number(output_number), .output_valid(output_valid),
    .busy(busy), .done(done),
`ifdef SAMPLE_STREAMER_LAST_EN
    .output_last(output_last),
`endif
    .fsm_state(fsm_state)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the buffer is a queue, the stream is "active" with a countdown of
  // cycles until the next emission.
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  bit           m_active = 0;
  int           m_gap    = 0;
  int           m_period = 0;
  logic [W-1:0] m_last   = '0;
  bit           m_over   = 0;
  int           cyc_n    = 0;
  bit           checks_on = 0;

  always @(posedge clk) begin
    bit ok;
    cyc_n++;
    if (!rst_n) begin
      exp_q.delete();
      m_active = 0;
      m_gap    = 0;
      m_last   = '0;
      m_over   = 0;
    end else begin
      ok = wr_en && (exp_q.size() < DEPTH);
      if (wr_en && !ok) m_over = 1;
      if (m_active && m_gap == 0) begin
        m_last = exp_q.pop_front();
        if (exp_q.size() + int'(ok) == 0) m_active = 0;
        else m_gap = m_period;
      end else if (m_active) begin
        m_gap--;
      end else if (start && exp_q.size() > 0) begin
        m_active = 1;
        m_gap    = 0;
        m_period = int'(rate_div);
      end
      if (ok) exp_q.push_back(wr_data);
    end
  end

  // logs of what the DUT emitted, for the directed literal checks
  logic [W-1:0] em_val[$];
  int           em_cyc[$];
  int           done_cyc[$];
  bit           em_last[$];

  // compare process: inputs change at posedge+1, outputs are checked at negedge
  always @(negedge clk) begin
    bit           e_valid, e_done, ok;
    logic [W-1:0] e_num;
    if (checks_on) begin
      ok      = wr_en && (exp_q.size() < DEPTH);
      e_valid = m_active && (m_gap == 0);
      e_done  = rst_n && e_valid && (exp_q.size() - 1 + int'(ok) == 0);
      e_num   = e_valid ? exp_q[0] : m_last;
      chk("valid",    32'(output_valid),  32'(e_valid));
      chk("number",   32'(output_number), 32'(e_num));
      chk("done",     32'(done),          32'(e_done));
      chk("busy",     32'(busy),          32'(m_active));
      chk("full",     32'(full),          32'(exp_q.size() == DEPTH));
      chk("overflow", 32'(overflow),      32'(m_over));
`ifdef SAMPLE_STREAMER_LAST_EN
      chk("last",     32'(output_last),   32'(e_done));
`endif
      if (output_valid === 1'b1) begin
        em_val.push_back(output_number);
        em_cyc.push_back(cyc_n);
`ifdef SAMPLE_STREAMER_LAST_EN
        em_last.push_back(output_last);
`else
        em_last.push_back(1'b0);
`endif
      end
      if (done === 1'b1) done_cyc.push_back(cyc_n);
    end
  end

  // driver tasks
  task automatic cyc(input logic we, input logic [W-1:0] d, input logic st);
    wr_en   = we;
    wr_data = d;
    start   = st;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    em_val.delete();
    em_cyc.delete();
    done_cyc.delete();
    em_last.delete();
  endtask

  initial begin
    // reset state
    do_reset();
    checks_on = 1;
    chk("rst_busy",     32'(busy),          32'd0);
    chk("rst_valid",    32'(output_valid),  32'd0);
    chk("rst_number",   32'(output_number), 32'd0);
    chk("rst_full",     32'(full),          32'd0);
    chk("rst_overflow", 32'(overflow),      32'd0);
    idle(2);

    // four words at full rate
    clear_logs();
    rate_div = 8'd0;
    cyc(1'b1, 16'd10, 1'b0);
    cyc(1'b1, 16'd20, 1'b0);
    cyc(1'b1, 16'd30, 1'b0);
    cyc(1'b1, 16'd40, 1'b0);
    cyc(1'b0, '0, 1'b1);
    idle(8);
    chk("t1_count", 32'(em_val.size()), 32'd4);
    if (em_val.size() == 4) begin
      chk("t1_v0", 32'(em_val[0]), 32'd10);
      chk("t1_v1", 32'(em_val[1]), 32'd20);
      chk("t1_v2", 32'(em_val[2]), 32'd30);
      chk("t1_v3", 32'(em_val[3]), 32'd40);
      chk("t1_back2back", 32'(em_cyc[3] - em_cyc[0]), 32'd3);
    end
    chk("t1_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() == 1 && em_cyc.size() == 4)
      chk("t1_done_with_last", 32'(done_cyc[0]), 32'(em_cyc[3]));
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_hold", 32'(output_number), 32'd40);

    // two words with rate_div=3
    clear_logs();
    rate_div = 8'd3;
    cyc(1'b1, 16'd5, 1'b0);
    cyc(1'b1, 16'd6, 1'b0);
    cyc(1'b0, '0, 1'b1);
    rate_div = 8'd9; // must not affect the running stream
    idle(12);
    chk("t2_count", 32'(em_val.size()), 32'd2);
    if (em_val.size() == 2) begin
      chk("t2_v0", 32'(em_val[0]), 32'd5);
      chk("t2_v1", 32'(em_val[1]), 32'd6);
      chk("t2_gap", 32'(em_cyc[1] - em_cyc[0]), 32'd4);
    end
    chk("t2_ndone", 32'(done_cyc.size()), 32'd1);

    // 17 pushes into a 16-deep buffer
    clear_logs();
    rate_div = 8'd0;
    for (int i = 1; i <= 16; i++) cyc(1'b1, 16'(i), 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
    cyc(1'b1, 16'd17, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, '0, 1'b1);
    idle(22);
    chk("t3_count", 32'(em_val.size()), 32'd16);
    if (em_val.size() == 16) begin
      chk("t3_first", 32'(em_val[0]),  32'd1);
      chk("t3_final", 32'(em_val[15]), 32'd16);
    end
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);

    // push coincident with the final pop keeps the stream alive
    clear_logs();
    rate_div = 8'd2;
    cyc(1'b1, 16'd7, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 16'd99, 1'b0); // this cycle is the EMIT of 7
    idle(8);
    chk("t4_count", 32'(em_val.size()), 32'd2);
    if (em_val.size() == 2) begin
      chk("t4_v0", 32'(em_val[0]), 32'd7);
      chk("t4_v1", 32'(em_val[1]), 32'd99);
      chk("t4_gap", 32'(em_cyc[1] - em_cyc[0]), 32'd3);
    end
    chk("t4_ndone", 32'(done_cyc.size()), 32'd1);

    // start on empty buffer, then reset during WAIT
    clear_logs();
    cyc(1'b0, '0, 1'b1);
    idle(3);
    chk("t5_empty_valid", 32'(em_val.size()), 32'd0);
    chk("t5_empty_done", 32'(done_cyc.size()), 32'd0);
    chk("t5_empty_busy", 32'(busy), 32'd0);
    rate_div = 8'd5;
    cyc(1'b1, 16'd1, 1'b0);
    cyc(1'b1, 16'd2, 1'b0);
    cyc(1'b0, '0, 1'b1);
    idle(2);
    chk("t5_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cyc(1'b1, 16'd55, 1'b1); // wr_en/start on a reset cycle are ignored
    rst_n = 1'b1;
    chk("t5_rst_busy",   32'(busy),          32'd0);
    chk("t5_rst_valid",  32'(output_valid),  32'd0);
    chk("t5_rst_number", 32'(output_number), 32'd0);
    chk("t5_rst_full",   32'(full),          32'd0);
    cyc(1'b0, '0, 1'b1); // buffer must be empty, so this start is ignored
    idle(10);
    chk("t5_emits", 32'(em_val.size()), 32'd1);
    chk("t5_no_done", 32'(done_cyc.size()), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

`ifdef SAMPLE_STREAMER_LAST_EN
    // output_last only on the third sample
    clear_logs();
    rate_div = 8'd1;
    cyc(1'b1, 16'd3, 1'b0);
    cyc(1'b1, 16'd4, 1'b0);
    cyc(1'b1, 16'd5, 1'b0);
    cyc(1'b0, '0, 1'b1);
    idle(10);
    chk("t6_count", 32'(em_last.size()), 32'd3);
    if (em_last.size() == 3) begin
      chk("t6_l0", 32'(em_last[0]), 32'd0);
      chk("t6_l1", 32'(em_last[1]), 32'd0);
      chk("t6_l2", 32'(em_last[2]), 32'd1);
    end
`endif

    checks_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
